l2_fill_arbiter: RTL

L2_FILL_ARBITER -- requirements
Module: l2_fill_arbiter

---
 rtl/l2_arb_pkg.sv | 22 ++
 rtl/rr_arb2.sv | 24 ++
 rtl/l2_fill_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/l2_arb_pkg.sv
// Shared types and constants for the L2 line-fill arbiter.
//   state_t      : fill FSM states
//   NUM_REQ      : number of miss handlers competing for L2
//   NUM_BEATS    : words per cache line fill
//   LINE_OFFS_W  : byte-offset bits inside a line
//   BEAT_W       : width of the in-line word index
//   DATA_W       : L2 word width
package l2_arb_pkg;

  localparam int unsigned NUM_REQ     = 2;
  localparam int unsigned NUM_BEATS   = 8;
  localparam int unsigned LINE_OFFS_W = 5;
  localparam int unsigned BEAT_W      = $clog2(NUM_BEATS);
  localparam int unsigned DATA_W      = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_LAST  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector.
//   i_req    : request vector
//   i_last   : index of the requester granted most recently
//   o_gnt_c  : one-hot grant (combinational)
module rr_arb2
  import l2_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_last,
  output logic [NUM_REQ-1:0] o_gnt_c
);

  // On a tie the requester that did not win last time is chosen.
  always_comb begin
    o_gnt_c = '0;
    unique case (i_req)
      2'b01:   o_gnt_c = 2'b01;
      2'b10:   o_gnt_c = 2'b10;
      2'b11:   o_gnt_c = i_last ? 2'b01 : 2'b10;
      default: o_gnt_c = '0;
    endcase
  end

endmodule

// File: rtl/l2_fill_arbiter.sv
// Arbitrates I-/D-cache line fills onto one L2 read port and streams the
// eight words of the granted line back to the winner.
//   clk, rst          : clock, async active-high reset
//   req, req_addr0/1  : fill requests and miss byte addresses
//   gnt               : one-hot grant held for the whole fill
//   l2_rd_en, l2_addr : L2 read strobe and word address
//   l2_rd_data        : L2 data, one cycle after l2_rd_en
//   fill_data/vld/beat: forwarded line word, valid, word index
//   fill_done         : one-cycle completion pulse to the winner
module l2_fill_arbiter
  import l2_arb_pkg::state_t, l2_arb_pkg::S_IDLE, l2_arb_pkg::S_BURST,
         l2_arb_pkg::S_LAST, l2_arb_pkg::NUM_REQ, l2_arb_pkg::LINE_OFFS_W,
         l2_arb_pkg::BEAT_W, l2_arb_pkg::DATA_W;
#(
  parameter int unsigned NUM_BEATS = l2_arb_pkg::NUM_BEATS,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [ADDR_W-1:0]    req_addr0,
  input  logic [ADDR_W-1:0]    req_addr1,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 l2_rd_en,
  output logic [ADDR_W-1:0]    l2_addr,
  input  logic [DATA_W-1:0]    l2_rd_data,
  output logic [DATA_W-1:0]    fill_data,
  output logic                 fill_vld,
  output logic [BEAT_W-1:0]    fill_beat,
  output logic [NUM_REQ-1:0]   fill_done
);

  localparam int unsigned LINE_W = ADDR_W - LINE_OFFS_W;

  state_t              r_state;
  logic [NUM_REQ-1:0]  r_gnt;
  logic                r_last;
  logic [LINE_W-1:0]   r_line;
  logic [BEAT_W-1:0]   r_beat;
  logic                r_rd_en;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_fill_vld;
  logic [BEAT_W-1:0]   r_fill_beat;
  logic [NUM_REQ-1:0]  r_done;

  logic [NUM_REQ-1:0]  w_arb_gnt;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [LINE_W-1:0]   w_sel_line;
  logic [BEAT_W-1:0]   w_beat_nxt;
  logic                w_unused_offs;

  rr_arb2 u_rr_arb2 (
    .i_req   (req),
    .i_last  (r_last),
    .o_gnt_c (w_arb_gnt)
  );

  assign w_sel_addr    = w_arb_gnt[1] ? req_addr1 : req_addr0;
  assign w_sel_line    = w_sel_addr[ADDR_W-1:LINE_OFFS_W];
  assign w_beat_nxt    = r_beat + BEAT_W'(1);
  // Byte offset within the line is irrelevant: whole lines are fetched.
  assign w_unused_offs = ^w_sel_addr[LINE_OFFS_W-1:0];

  // Fill FSM with registered grant, L2 request and fill-return outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_gnt       <= '0;
      r_last      <= 1'b1;
      r_line      <= '0;
      r_beat      <= '0;
      r_rd_en     <= 1'b0;
      r_addr      <= '0;
      r_fill_vld  <= 1'b0;
      r_fill_beat <= '0;
      r_done      <= '0;
    end else begin
      // Return path trails the L2 strobe by exactly one cycle.
      r_fill_vld  <= r_rd_en;
      r_fill_beat <= r_rd_en ? r_beat : '0;
      r_done      <= '0;
      unique case (r_state)
        S_IDLE: begin
          r_beat <= '0;
          if (req != '0) begin
            r_gnt   <= w_arb_gnt;
            r_last  <= w_arb_gnt[1];
            r_line  <= w_sel_line;
            r_rd_en <= 1'b1;
            r_addr  <= ADDR_W'({w_sel_line, BEAT_W'(0)});
            r_state <= S_BURST;
          end
        end
        S_BURST: begin
          if (r_beat == BEAT_W'(NUM_BEATS - 1)) begin
            r_rd_en <= 1'b0;
            r_addr  <= '0;
            r_beat  <= '0;
            r_done  <= r_gnt;
            r_state <= S_LAST;
          end else begin
            r_beat <= w_beat_nxt;
            r_addr <= ADDR_W'({r_line, w_beat_nxt});
          end
        end
        S_LAST: begin
          r_gnt   <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign l2_rd_en  = r_rd_en;
  assign l2_addr   = r_addr;
  assign fill_vld  = r_fill_vld;
  assign fill_beat = r_fill_beat;
  assign fill_done = r_done;
  // L2 data arrives in the fill_vld cycle, so it is forwarded unregistered.
  assign fill_data = r_fill_vld ? l2_rd_data : '0;

endmodule
